// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner: 2-flop synchroniser, stability-count debounce,
// and a per-channel press/long-press FSM producing one-cycle event pulses.
module btn_debounce_multi #(
    parameter int N_CH       = 4,
    parameter int STABLE_CNT = 1000,
    parameter int LONG_CYC   = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_long,
    output logic            any_active
);

    localparam int CNT_W  = ($clog2(STABLE_CNT + 1) < 1) ? 1 : $clog2(STABLE_CNT + 1);
    localparam int LONG_W = ($clog2(LONG_CYC + 1) < 1) ? 1 : $clog2(LONG_CYC + 1);

    localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [LONG_W-1:0] LONG_LAST   = (LONG_CYC == 0) ? '0 : LONG_W'(LONG_CYC - 1);
    localparam logic [LONG_W-1:0] LONG_SAT    = LONG_W'(LONG_CYC);

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_HELD     = 2'd2
    } state_e;

    logic [N_CH-1:0]   s1_q, s2_q;
    logic [CNT_W-1:0]  cnt_q [N_CH];
    logic [CNT_W-1:0]  cnt_d [N_CH];
    logic [N_CH-1:0]   level_q, level_d;
    logic [LONG_W-1:0] hold_q [N_CH];
    state_e            state_q [N_CH];
    logic [N_CH-1:0]   press_q, release_q, long_q;
    logic              any_q;

    // Stability qualification: a changed level is accepted only after STABLE_CNT
    // consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            // NOTE: defaults first so every path assigns every output -> no latches.
            level_d[i] = level_q[i];
            cnt_d[i]   = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == STABLE_LAST) begin
                    level_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: every register here uses <= so all state updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the per-channel arrays are a handful of flops, not RAM, so they are reset.
            s1_q      <= '0;
            s2_q      <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            any_q     <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]   <= '0;
                hold_q[i]  <= '0;
                state_q[i] <= ST_RELEASED;
            end
        end else begin
            s1_q      <= btn_in;
            s2_q      <= s1_q;
            level_q   <= level_d;
            any_q     <= |level_d;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                case (state_q[i])
                    ST_RELEASED: begin
                        if (level_d[i]) begin
                            state_q[i] <= ST_PRESSED;
                            press_q[i] <= 1'b1;
                            hold_q[i]  <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (!level_d[i]) begin
                            state_q[i]   <= ST_RELEASED;
                            release_q[i] <= 1'b1;
                        end else if (LONG_CYC != 0) begin
                            // Fires on the LONG_CYC-th edge after the press edge.
                            if (hold_q[i] == LONG_LAST) begin
                                state_q[i] <= ST_HELD;
                                long_q[i]  <= 1'b1;
                                hold_q[i]  <= LONG_SAT;
                            end else begin
                                hold_q[i] <= hold_q[i] + LONG_W'(1);
                            end
                        end
                    end
                    ST_HELD: begin
                        if (!level_d[i]) begin
                            state_q[i]   <= ST_RELEASED;
                            release_q[i] <= 1'b1;
                        end
                    end
                    default: state_q[i] <= ST_RELEASED;
                endcase
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;
    assign any_active  = any_q;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Scoreboard bench for btn_debounce_multi (N_CH=2, STABLE_CNT=4, LONG_CYC=10): stimulus
// pushes expected pulse events, a negedge monitor pops and compares each DUT event.
module tb_btn_debounce_multi;

    localparam int N_CH = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] btn_level, btn_press, btn_release, btn_long;
    logic            any_active;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int              at;
        logic [N_CH-1:0] press;
        logic [N_CH-1:0] rel;
        logic [N_CH-1:0] lng;
        logic [N_CH-1:0] level;
        logic            any;
    } evt_t;

    evt_t sb_q [$];

    btn_debounce_multi #(
        .N_CH(N_CH), .STABLE_CNT(4), .LONG_CYC(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_long(btn_long), .any_active(any_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_evt(input int at, input logic [N_CH-1:0] press, input logic [N_CH-1:0] rel,
                              input logic [N_CH-1:0] lng, input logic [N_CH-1:0] level, input logic any);
        evt_t e;
        e.at = at; e.press = press; e.rel = rel; e.lng = lng; e.level = level; e.any = any;
        sb_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any pulse on any channel is an event that must match the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (btn_press | btn_release | btn_long) != '0) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_evt", {btn_press, btn_release, btn_long}, '0);
            end else begin
                evt_t e;
                e = sb_q.pop_front();
                check("evt_cycle", cyc, e.at);
                check("evt_press", btn_press, e.press);
                check("evt_release", btn_release, e.rel);
                check("evt_long", btn_long, e.lng);
                check("evt_level", btn_level, e.level);
                check("evt_any_active", any_active, e.any);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_level"}, btn_level, '0);
        check({tag, "_press"}, btn_press, '0);
        check({tag, "_release"}, btn_release, '0);
        check({tag, "_long"}, btn_long, '0);
        check({tag, "_any"}, any_active, 1'b0);
    endtask

    initial begin
        int t;
        rst_n  = 1'b0;
        btn_in = '0;
        wait_cyc(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        wait_cyc(3);

        // 1. Clean press on ch0, held 30 clocks: press at E0+5, long at E0+15, then release.
        t = cyc;
        btn_in = 2'b01;
        expect_evt(t + 6, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
        expect_evt(t + 16, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1);
        wait_cyc(5);
        check("t1_level_before_latency", btn_level, 2'b00);
        wait_cyc(1);
        check("t1_level_at_latency", btn_level, 2'b01);
        check("t1_any_at_latency", any_active, 1'b1);
        wait_cyc(24);
        t = cyc;
        btn_in = 2'b00;
        expect_evt(t + 6, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        wait_cyc(10);

        // 2. Bounce every 2 clocks for 12 clocks, then settle high: one press after settle.
        for (int k = 0; k < 6; k++) begin
            btn_in[0] = (k % 2 == 0);
            wait_cyc(2);
        end
        check("t2_no_level_during_bounce", btn_level, 2'b00);
        t = cyc;
        btn_in[0] = 1'b1;
        expect_evt(t + 6, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
        expect_evt(t + 16, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1);
        wait_cyc(20);
        t = cyc;
        btn_in[0] = 1'b0;
        expect_evt(t + 6, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        wait_cyc(10);

        // 3. Glitch on ch1 shorter than the qualification window.
        btn_in[1] = 1'b1;
        wait_cyc(3);
        btn_in[1] = 1'b0;
        wait_cyc(10);
        check("t3_glitch_level", btn_level, 2'b00);

        // 4. Short press: level high 6 clocks, release 5 edges after input fall, no long.
        t = cyc;
        btn_in[0] = 1'b1;
        expect_evt(t + 6, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
        wait_cyc(6);
        t = cyc;
        btn_in[0] = 1'b0;
        expect_evt(t + 6, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        wait_cyc(20);

        // 5. Simultaneous press; ch0 releases while ch1 holds through its long press.
        t = cyc;
        btn_in = 2'b11;
        expect_evt(t + 6, 2'b11, 2'b00, 2'b00, 2'b11, 1'b1);
        expect_evt(t + 14, 2'b00, 2'b01, 2'b00, 2'b10, 1'b1);
        expect_evt(t + 16, 2'b00, 2'b00, 2'b10, 2'b10, 1'b1);
        wait_cyc(8);
        btn_in = 2'b10;
        wait_cyc(14);
        t = cyc;
        btn_in = 2'b00;
        expect_evt(t + 6, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
        wait_cyc(10);

        // 6. Reset with ch0 HELD and ch1 mid-qualification.
        t = cyc;
        btn_in = 2'b01;
        expect_evt(t + 6, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
        expect_evt(t + 16, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1);
        wait_cyc(20);
        btn_in = 2'b11;
        wait_cyc(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        wait_cyc(3);
        t = cyc;
        rst_n = 1'b1;
        expect_evt(t + 6, 2'b11, 2'b00, 2'b00, 2'b11, 1'b1);
        expect_evt(t + 16, 2'b00, 2'b00, 2'b11, 2'b11, 1'b1);
        wait_cyc(25);
        check("t6_level_held", btn_level, 2'b11);

        check("sb_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
